// File: rtl/gaussian_line_buffer_5row_if.sv
// Pixel-stream interface of the 5-row line buffer: raster pixels in, one vertical column out.
interface gaussian_line_buffer_5row_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int COL_W       = 10,
    parameter int ROW_W       = 9
);
    logic                   enable;
    logic                   valid_in;
    logic                   sof_in;
    logic [PIXEL_WIDTH-1:0] pixel_in;
    logic [PIXEL_WIDTH-1:0] win_row_0;
    logic [PIXEL_WIDTH-1:0] win_row_1;
    logic [PIXEL_WIDTH-1:0] win_row_2;
    logic [PIXEL_WIDTH-1:0] win_row_3;
    logic [PIXEL_WIDTH-1:0] win_row_4;
    logic                   valid_out;
    logic [COL_W-1:0]       out_col;
    logic [ROW_W-1:0]       out_row;

    modport master (
        output enable, valid_in, sof_in, pixel_in,
        input  win_row_0, win_row_1, win_row_2, win_row_3, win_row_4,
        input  valid_out, out_col, out_row
    );

    modport slave (
        input  enable, valid_in, sof_in, pixel_in,
        output win_row_0, win_row_1, win_row_2, win_row_3, win_row_4,
        output valid_out, out_col, out_row
    );
endinterface

// File: rtl/gaussian_line_buffer_5row.sv
// Four-line buffer emitting a 5-pixel vertical column per accepted pixel, gated by FILL/STREAM.
// Define GAUSS_LB_ZERO_FILL_EN to emit from row 0 with top-border rows forced to zero.
module gaussian_line_buffer_5row #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int COL_W       = $clog2(IMG_WIDTH),
    parameter int ROW_W       = $clog2(IMG_HEIGHT)
) (
    input  logic                        clk,
    input  logic                        rst,
    gaussian_line_buffer_5row_if.slave  bus
);
    typedef enum logic {StFill, StStream} state_e;

    localparam logic [COL_W-1:0] LastCol = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LastRow = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] FillRow = ROW_W'(3);

    state_e                 r_state, w_state, w_state_nxt;
    logic [COL_W-1:0]       r_col, w_col, w_col_nxt;
    logic [ROW_W-1:0]       r_row, w_row, w_row_nxt;
    logic                   w_accept;
    logic                   w_valid_nxt;
    logic [3:0]             w_mask;

    logic [PIXEL_WIDTH-1:0] r_l1 [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] r_l2 [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] r_l3 [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] r_l4 [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] w_rd1, w_rd2, w_rd3, w_rd4;

    logic [PIXEL_WIDTH-1:0] r_win0, r_win1, r_win2, r_win3, r_win4;
    logic                   r_valid;
    logic [COL_W-1:0]       r_out_col;
    logic [ROW_W-1:0]       r_out_row;

    assign w_accept = bus.enable & bus.valid_in;

    // sof_in relocates the current pixel to (0,0) of a fresh frame before anything else
    assign w_col   = bus.sof_in ? '0 : r_col;
    assign w_row   = bus.sof_in ? '0 : r_row;
    assign w_state = bus.sof_in ? StFill : r_state;

    assign w_rd1 = r_l1[w_col];
    assign w_rd2 = r_l2[w_col];
    assign w_rd3 = r_l3[w_col];
    assign w_rd4 = r_l4[w_col];

    always_comb begin
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_state_nxt = r_state;
        if (w_accept) begin
            w_col_nxt   = w_col + 1'b1;
            w_row_nxt   = w_row;
            w_state_nxt = w_state;
            if (w_col == LastCol) begin
                w_col_nxt = '0;
                if (w_row == LastRow) begin
                    w_row_nxt   = '0;
                    w_state_nxt = StFill;
                end else begin
                    w_row_nxt = w_row + 1'b1;
                    if (w_row == FillRow) begin
                        w_state_nxt = StStream;
                    end
                end
            end
        end
    end

    always_comb begin
`ifdef GAUSS_LB_ZERO_FILL_EN
        w_valid_nxt = 1'b1;
        // bit k-1 masks the line k rows above, which lies above the frame while y < k
        w_mask[0]   = (w_state == StFill) && (w_row < ROW_W'(1));
        w_mask[1]   = (w_state == StFill) && (w_row < ROW_W'(2));
        w_mask[2]   = (w_state == StFill) && (w_row < ROW_W'(3));
        w_mask[3]   = (w_state == StFill) && (w_row < ROW_W'(4));
`else
        w_valid_nxt = (w_state == StStream);
        w_mask      = '0;
`endif
    end

    // Line memories: cascaded shift at one address, reads taken before the write
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_l4[w_col] <= w_rd3;
            r_l3[w_col] <= w_rd2;
            r_l2[w_col] <= w_rd1;
            r_l1[w_col] <= bus.pixel_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StFill;
            r_col   <= '0;
            r_row   <= '0;
        end else if (bus.enable) begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win0    <= '0;
            r_win1    <= '0;
            r_win2    <= '0;
            r_win3    <= '0;
            r_win4    <= '0;
            r_valid   <= 1'b0;
            r_out_col <= '0;
            r_out_row <= '0;
        end else if (w_accept) begin
            r_win0    <= w_mask[3] ? '0 : w_rd4;
            r_win1    <= w_mask[2] ? '0 : w_rd3;
            r_win2    <= w_mask[1] ? '0 : w_rd2;
            r_win3    <= w_mask[0] ? '0 : w_rd1;
            r_win4    <= bus.pixel_in;
            r_valid   <= w_valid_nxt;
            r_out_col <= w_col;
            r_out_row <= w_row;
        end else if (bus.enable) begin
            r_valid   <= 1'b0;
        end
    end

    assign bus.win_row_0 = r_win0;
    assign bus.win_row_1 = r_win1;
    assign bus.win_row_2 = r_win2;
    assign bus.win_row_3 = r_win3;
    assign bus.win_row_4 = r_win4;
    assign bus.valid_out = r_valid;
    assign bus.out_col   = r_out_col;
    assign bus.out_row   = r_out_row;
endmodule

// File: tb/tb_gaussian_line_buffer_5row.sv
// Randomized bench for gaussian_line_buffer_5row against a frame-image reference model.
module tb_gaussian_line_buffer_5row;
    localparam int PW = 8;
    localparam int IW = 8;
    localparam int IH = 8;
    localparam int CW = 3;
    localparam int RW = 3;
`ifdef GAUSS_LB_ZERO_FILL_EN
    localparam bit ZeroFill = 1'b1;
`else
    localparam bit ZeroFill = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gaussian_line_buffer_5row_if #(.PIXEL_WIDTH(PW), .COL_W(CW), .ROW_W(RW)) bus ();

    gaussian_line_buffer_5row #(
        .PIXEL_WIDTH(PW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .COL_W(CW), .ROW_W(RW)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: the frame as written so far, plus the expected output registers
    logic [PW-1:0] img [IH][IW];
    int            m_x, m_y;
    logic [PW-1:0] e_win [5];
    logic          e_valid;
    int            e_col, e_row;
    int            n_err = 0;
    int            n_chk = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = 0;
        m_y = 0;
        e_valid = 1'b0;
        e_col = 0;
        e_row = 0;
        for (int k = 0; k < 5; k++) e_win[k] = '0;
    endtask

    task automatic compare_outputs();
        check("valid_out", {31'd0, bus.valid_out}, {31'd0, e_valid});
        if (e_valid) begin
            check("win_row_0", 32'(bus.win_row_0), 32'(e_win[0]));
            check("win_row_1", 32'(bus.win_row_1), 32'(e_win[1]));
            check("win_row_2", 32'(bus.win_row_2), 32'(e_win[2]));
            check("win_row_3", 32'(bus.win_row_3), 32'(e_win[3]));
            check("win_row_4", 32'(bus.win_row_4), 32'(e_win[4]));
            check("out_col", 32'(bus.out_col), 32'(e_col));
            check("out_row", 32'(bus.out_row), 32'(e_row));
        end
    endtask

    task automatic step(input logic en, input logic vld, input logic sof, input logic [PW-1:0] pix);
        @(negedge clk);
        bus.enable   = en;
        bus.valid_in = vld;
        bus.sof_in   = sof;
        bus.pixel_in = pix;
        @(posedge clk);
        if (en && vld) begin
            if (sof) begin
                m_x = 0;
                m_y = 0;
            end
            img[m_y][m_x] = pix;
            e_valid = ZeroFill || (m_y >= 4);
            for (int k = 0; k <= 4; k++)
                e_win[4-k] = (m_y >= k) ? img[m_y-k][m_x] : '0;
            e_col = m_x;
            e_row = m_y;
            m_x++;
            if (m_x == IW) begin
                m_x = 0;
                m_y = (m_y + 1) % IH;
            end
        end else if (en) begin
            e_valid = 1'b0;
        end
        #1;
        compare_outputs();
    endtask

    // One accepted pixel, optionally preceded by random bubbles and stalls
    task automatic pixel(input bit stalls, input logic sof, input logic [PW-1:0] pix);
        if (stalls && ($urandom_range(3) == 0))
            step(1'b1, 1'b0, 1'($urandom), PW'($urandom));
        if (stalls && ($urandom_range(7) == 0))
            step(1'b0, 1'b1, 1'($urandom), PW'($urandom));
        step(1'b1, 1'b1, sof, pix);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, bus.valid_out}, 32'd0);
        check({tag, "_win"}, {bus.win_row_0, bus.win_row_1, bus.win_row_2, bus.win_row_3}, 32'd0);
        check({tag, "_win4"}, 32'(bus.win_row_4), 32'd0);
        check({tag, "_pos"}, 32'({bus.out_col, bus.out_row}), 32'd0);
    endtask

    int pulses;
    int next_col;

    initial begin
        bus.enable   = 1'b0;
        bus.valid_in = 1'b0;
        bus.sof_in   = 1'b0;
        bus.pixel_in = '0;
        rst = 1'b1;
        model_reset();
        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Frame A: row*16+col, no sof needed after reset
        for (int y = 0; y < IH; y++) begin
            for (int x = 0; x < IW; x++) begin
                pixel(1'b1, 1'b0, PW'(y * 16 + x));
                if (!ZeroFill && y == 4 && x == 2) begin
                    check("a42_valid", {31'd0, bus.valid_out}, 32'd1);
                    check("a42_win", {bus.win_row_0, bus.win_row_1, bus.win_row_2, bus.win_row_3},
                          32'h02122232);
                    check("a42_win4", 32'(bus.win_row_4), 32'h42);
                    check("a42_pos", 32'({bus.out_row, bus.out_col}), 32'({3'd4, 3'd2}));
                end
                if (ZeroFill && y == 1 && x == 5) begin
                    check("zf15_valid", {31'd0, bus.valid_out}, 32'd1);
                    check("zf15_win", {bus.win_row_0, bus.win_row_1, bus.win_row_2, bus.win_row_3},
                          32'h00000005);
                    check("zf15_win4", 32'(bus.win_row_4), 32'h15);
                end
            end
        end

        // Frame B: +0x80 with sof, a 3-cycle enable stall in row 5, bubbles in row 6
        for (int y = 0; y < IH; y++) begin
            if (y == 6) pulses = 0;
            next_col = 0;
            for (int x = 0; x < IW; x++) begin
                if (y == 5 && x == 4)
                    for (int s = 0; s < 3; s++) step(1'b0, 1'b1, 1'b0, PW'($urandom));
                if (y == 6) begin
                    step(1'b1, 1'b0, 1'b0, PW'($urandom));
                    if (bus.valid_out) pulses++;
                    step(1'b1, 1'b1, 1'b0, PW'(8'h80 + y * 16 + x));
                    if (bus.valid_out) begin
                        pulses++;
                        check("row6_col_order", 32'(bus.out_col), 32'(next_col));
                        next_col++;
                    end
                end else begin
                    pixel(y != 5, (y == 0 && x == 0), PW'(8'h80 + y * 16 + x));
                end
                if (y == 5 && x == 7) begin
                    check("b57_win", {bus.win_row_0, bus.win_row_1, bus.win_row_2, bus.win_row_3},
                          32'h97A7B7C7);
                    check("b57_win4", 32'(bus.win_row_4), 32'hD7);
                end
            end
            if (y == 6) check("row6_pulses", 32'(pulses), 32'd8);
        end

        // Frame C: random pixels, restarted by sof at row 6 col 3
        for (int i = 0; i < 6 * IW + 3; i++) pixel(1'b1, (i == 0), PW'($urandom));
        for (int i = 0; i < 5 * IW + 4; i++) pixel(1'b1, (i == 0), PW'($urandom));

        // Asynchronous reset mid-line, then a sof-less frame
        @(negedge clk);
        bus.valid_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6 * IW; i++) pixel(1'b1, 1'b0, PW'($urandom));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
